// File: rtl/ama_riscv_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// ama_riscv_rf_wb_arbiter
//
// Arbitrates register-file writeback between two requesters:
//   req0 - the core writeback path
//   req1 - long-latency units such as load and multiply
// The module grants at most one request per cycle. When both requesters are
// valid, a 1-bit round-robin pointer picks the winner. The accepted write
// reaches the register-file write port one cycle later. Writes to x0 complete
// the handshake but never assert rf_we.
//
// An optional pending-write scoreboard is built in when the macro
// RF_WB_ARB_SCOREBOARD_EN is defined. Issue marks a destination register as
// busy. An accepted writeback to that register clears the mark. The hazard
// outputs report the busy state of two source registers. When the macro is
// undefined, busy_vec, hazard_a and hazard_b are tied to 0.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   req0_valid/ready/addr/data   core writeback request and grant
//   req1_valid/ready/addr/data   long-latency writeback request and grant
//   rf_we, rf_addr_d, rf_data_d  registered register-file write port
//   sb_set_valid, sb_set_addr    issue-stage "mark pending" request
//   rd_addr_a, rd_addr_b         source registers to check for hazards
//   hazard_a, hazard_b           source has a pending write
//   busy_vec                     pending-write bitmap (bit i = xi)
// -----------------------------------------------------------------------------
module ama_riscv_rf_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        rf_we,
    output logic [4:0]  rf_addr_d,
    output logic [31:0] rf_data_d,
    input  logic        sb_set_valid,
    input  logic [4:0]  sb_set_addr,
    input  logic [4:0]  rd_addr_a,
    input  logic [4:0]  rd_addr_b,
    output logic        hazard_a,
    output logic        hazard_b,
    output logic [31:0] busy_vec
);

    logic        rr_ptr_q, rr_ptr_d;     // 0: req0 has priority on contention
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic        grant0, grant1, accept, do_write;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    // Grants are combinational from the valids and the pointer. Reset masks
    // both grants, so no request is taken while rst is high.
    always_comb begin
        grant0   = ~rst & req0_valid & (~req1_valid | ~rr_ptr_q);
        grant1   = ~rst & req1_valid & (~req0_valid |  rr_ptr_q);
        accept   = grant0 | grant1;
        sel_addr = grant1 ? req1_addr : req0_addr;
        sel_data = grant1 ? req1_data : req0_data;
        // An x0 write completes the handshake but is dropped here.
        do_write = accept & (sel_addr != 5'd0);

        // After a grant to reqN, priority passes to the other requester.
        rr_ptr_d  = accept ? grant0 : rr_ptr_q;
        wr_en_d   = do_write;
        // The write port holds its last real write when idle.
        wr_addr_d = do_write ? sel_addr : wr_addr_q;
        wr_data_d = do_write ? sel_data : wr_data_q;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples values from before the edge regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= 32'd0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign rf_we     = wr_en_q;
    assign rf_addr_d = wr_addr_q;
    assign rf_data_d = wr_data_q;

`ifdef RF_WB_ARB_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    // The clear is applied first and the set second, so a same-address
    // collision leaves the register busy. A newer issue outranks the
    // retiring write.
    always_comb begin
        busy_d = busy_q;
        if (accept) begin
            busy_d[sel_addr] = 1'b0;
        end
        if (sb_set_valid && (sb_set_addr != 5'd0)) begin
            busy_d[sb_set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;
    assign hazard_a = busy_q[rd_addr_a];
    assign hazard_b = busy_q[rd_addr_b];
`else
    assign busy_vec = 32'd0;
    assign hazard_a = 1'b0;
    assign hazard_b = 1'b0;

    // The scoreboard inputs have no function in this build.
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{sb_set_valid, sb_set_addr, rd_addr_a, rd_addr_b};
`endif

endmodule

// File: tb/tb_ama_riscv_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ama_riscv_rf_wb_arbiter
//
// Directed bench for ama_riscv_rf_wb_arbiter. Each cycle, a small reference
// model predicts the grants and the hazard outputs before the clock edge. It
// also pushes the expected write-port contents for the next cycle onto a queue.
// After the edge, the bench pops that entry and compares it against the DUT.
// Expected scoreboard behaviour follows RF_WB_ARB_SCOREBOARD_EN.
// -----------------------------------------------------------------------------
module tb_ama_riscv_rf_wb_arbiter;

`ifdef RF_WB_ARB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid, req1_ready;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        rf_we;
    logic [4:0]  rf_addr_d;
    logic [31:0] rf_data_d;
    logic        sb_set_valid;
    logic [4:0]  sb_set_addr;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic        hazard_a, hazard_b;
    logic [31:0] busy_vec;

    ama_riscv_rf_wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .rf_we        (rf_we),
        .rf_addr_d    (rf_addr_d),
        .rf_data_d    (rf_data_d),
        .sb_set_valid (sb_set_valid),
        .sb_set_addr  (sb_set_addr),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .hazard_a     (hazard_a),
        .hazard_b     (hazard_b),
        .busy_vec     (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        known;   // addr/data are defined for this entry
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic        m_rr;
    logic [31:0] m_busy;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_known;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle. The inputs must already be driven, after a negedge.
    task automatic tick();
        logic        g0, g1, acc, we;
        logic [4:0]  sa;
        logic [31:0] sd;
        logic [31:0] nb;
        exp_t        e;

        #1;
        g0 = !rst && req0_valid && (!req1_valid || !m_rr);
        g1 = !rst && req1_valid && (!req0_valid ||  m_rr);
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
        chk("hazard_a", {31'd0, hazard_a}, {31'd0, SB_EN & m_busy[rd_addr_a]});
        chk("hazard_b", {31'd0, hazard_b}, {31'd0, SB_EN & m_busy[rd_addr_b]});

        if (rst) begin
            m_rr = 1'b0; m_busy = 32'd0; m_addr = 5'd0; m_data = 32'd0; m_known = 1'b1;
            we = 1'b0;
        end else begin
            acc = g0 | g1;
            sa  = g1 ? req1_addr : req0_addr;
            sd  = g1 ? req1_data : req0_data;
            nb  = m_busy;
            if (acc) begin
                nb[sa] = 1'b0;
                m_rr   = g0;
            end
            if (sb_set_valid && sb_set_addr != 5'd0) nb[sb_set_addr] = 1'b1;
            m_busy = nb;
            we = acc && (sa != 5'd0);
            if (we) begin
                m_addr = sa; m_data = sd; m_known = 1'b1;
            end else if (acc) begin
                m_known = 1'b0;   // dropped x0 write: port contents left unchecked
            end
        end
        e.we = we; e.addr = m_addr; e.data = m_data; e.known = m_known;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = exp_q.pop_front();
            chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
            if (e.known) begin
                chk("rf_addr_d", {27'd0, rf_addr_d}, {27'd0, e.addr});
                chk("rf_data_d", rf_data_d, e.data);
            end
        end
        chk("busy_vec", busy_vec, SB_EN ? m_busy : 32'd0);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
        req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
        sb_set_valid = 1'b0; sb_set_addr = 5'd0;
    endtask

    initial begin
        int seq [4];
        seq = '{3, 4, 3, 4};
        m_rr = 1'b0; m_busy = 32'd0; m_addr = 5'd0; m_data = 32'd0; m_known = 1'b0;
        idle_inputs();
        rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        tick();
        tick();
        chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
        chk("reset_busy", busy_vec, 32'd0);
        rst = 1'b0;

        // Single request on req0
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        #1 chk("single_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        chk("single_we", {31'd0, rf_we}, 32'd1);
        chk("single_addr", {27'd0, rf_addr_d}, 32'd5);
        chk("single_data", rf_data_d, 32'hDEADBEEF);
        idle_inputs();
        tick();
        chk("single_we_drop", {31'd0, rf_we}, 32'd0);

        // Contention from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1 chk("contention_grant0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            tick();
            chk("contention_addr", {27'd0, rf_addr_d}, seq[i]);
        end
        idle_inputs();
        tick();

        // x0 write on req1
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFFFFFF;
        #1 chk("x0_ready", {31'd0, req1_ready}, 32'd1);
        tick();
        chk("x0_we", {31'd0, rf_we}, 32'd0);
        idle_inputs();
        tick();

        // Scoreboard set, hazard, then clear by a writeback
        sb_set_valid = 1'b1; sb_set_addr = 5'd10;
        tick();
        idle_inputs();
        rd_addr_a = 5'd10;
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'h0A0A0A0A;
        #1 chk("sb_hazard_set", {31'd0, hazard_a}, {31'd0, SB_EN});
        tick();
        idle_inputs();
        #1 chk("sb_hazard_clear", {31'd0, hazard_a}, 32'd0);
        tick();

        // Set and clear to the same address in one cycle
        sb_set_valid = 1'b1; sb_set_addr = 5'd7;
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
        tick();
        idle_inputs();
        chk("collision_busy7", {31'd0, busy_vec[7]}, {31'd0, SB_EN});
        rd_addr_b = 5'd7;
        tick();

        // Mid-operation reset with x7 and x10 busy
        sb_set_valid = 1'b1; sb_set_addr = 5'd10;
        tick();
        idle_inputs();
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h1;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h2;
        tick();
        chk("pre_reset_busy", busy_vec, SB_EN ? 32'h00000480 : 32'd0);
        rst = 1'b1;
        sb_set_valid = 1'b1; sb_set_addr = 5'd12;   // must be ignored
        #1 chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        tick();
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_busy", busy_vec, 32'd0);
        rst = 1'b0;
        sb_set_valid = 1'b0; sb_set_addr = 5'd0;
        #1 chk("post_rst_grant0", {31'd0, req0_ready}, 32'd1);
        tick();
        tick();
        idle_inputs();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
